// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: button front end, run/pause/lap FSM and display select
// for the stop_watch millisecond counter.
// Optional feature macro: STOP_WATCH_DEBOUNCE_EN adds a DEB_CYCLES-cycle
// stability filter between the synchronizer and the edge detector.
module stop_watch_ctrl #(
  parameter int W          = 32,
  parameter int DEB_CYCLES = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_ss,
  input  logic         btn_lr,
  input  logic [W-1:0] nrms,
  output logic         run_en,
  output logic         cnt_clr,
  output logic [W-1:0] lap_val,
  output logic [3:0]   lap_cnt,
  output logic [W-1:0] disp_ms,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Bit 0 carries start/stop, bit 1 carries lap/reset throughout the front end.
  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] lvl;
  logic [1:0] lvl_d;
  logic [1:0] pulse;

  state_t         state_q;
  state_t         state_d;
  logic           run_d;
  logic           clr_d;
  logic [W-1:0]   lap_val_d;
  logic [3:0]     lap_cnt_d;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {btn_lr, btn_ss};
      sync_p1 <= sync_p0;
    end
  end

`ifdef STOP_WATCH_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] deb_cnt [2];

  // Debounced level follows the synchronized level only after it has
  // differed for DEB_CYCLES consecutive cycles; any return resets the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      lvl        <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          lvl[i]     <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign lvl = sync_p1;
`endif

  // Registered rising-edge detector: one pulse per press, none while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_d <= '0;
      pulse <= '0;
    end else begin
      lvl_d <= lvl;
      pulse <= lvl & ~lvl_d;
    end
  end

  // Next-state and next-output logic; start/stop has priority over lap/reset.
  always_comb begin
    state_d   = state_q;
    clr_d     = 1'b0;
    lap_val_d = lap_val;
    lap_cnt_d = lap_cnt;
    unique case (state_q)
      IDLE: begin
        if (pulse[0]) state_d = RUN;
      end
      RUN: begin
        if (pulse[0]) begin
          state_d = PAUSE;
        end else if (pulse[1]) begin
          state_d   = LAP;
          lap_val_d = nrms;
          if (lap_cnt != 4'd15) lap_cnt_d = lap_cnt + 4'd1;
        end
      end
      LAP: begin
        if (pulse[0])      state_d = PAUSE;
        else if (pulse[1]) state_d = RUN;
      end
      PAUSE: begin
        if (pulse[0]) begin
          state_d = RUN;
        end else if (pulse[1]) begin
          state_d   = IDLE;
          clr_d     = 1'b1;
          lap_val_d = '0;
          lap_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN) || (state_d == LAP);
  end

  // State and control outputs, all registered off the event pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      run_en  <= 1'b0;
      cnt_clr <= 1'b0;
      lap_val <= '0;
      lap_cnt <= '0;
    end else begin
      state_q <= state_d;
      run_en  <= run_d;
      cnt_clr <= clr_d;
      lap_val <= lap_val_d;
      lap_cnt <= lap_cnt_d;
    end
  end

  // Display register: frozen lap value in LAP, live count otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_ms <= '0;
    end else begin
      disp_ms <= (state_q == LAP) ? lap_val : nrms;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed testbench for stop_watch_ctrl; works in both the default and
// the STOP_WATCH_DEBOUNCE_EN build (DEB_CYCLES = 8).
module tb_stop_watch_ctrl;

  localparam int W   = 32;
  localparam int DEB = 8;
`ifdef STOP_WATCH_DEBOUNCE_EN
  localparam int DEB_LAT = DEB;
`else
  localparam int DEB_LAT = 0;
`endif
  localparam int PRESS  = 5 + DEB_LAT;
  localparam int SETTLE = 8 + DEB_LAT;

  logic         clk;
  logic         rst;
  logic         btn_ss;
  logic         btn_lr;
  logic [W-1:0] nrms;
  logic         run_en;
  logic         cnt_clr;
  logic [W-1:0] lap_val;
  logic [3:0]   lap_cnt;
  logic [W-1:0] disp_ms;
  logic [1:0]   state;

  int n_tests = 0;
  int n_fail  = 0;

  stop_watch_ctrl #(.W(W), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .nrms    (nrms),
    .run_en  (run_en),
    .cnt_clr (cnt_clr),
    .lap_val (lap_val),
    .lap_cnt (lap_cnt),
    .disp_ms (disp_ms),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit lr, input int n);
    if (lr) btn_lr = 1'b1; else btn_ss = 1'b1;
    repeat (n) step();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (SETTLE) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    nrms   = '0;
    repeat (3) step();

    chk("rst_state",   state,   0);
    chk("rst_run_en",  run_en,  0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_lap_val", lap_val, 0);
    chk("rst_lap_cnt", lap_cnt, 0);
    chk("rst_disp",    disp_ms, 0);

    rst = 1'b1;
    repeat (2) step();

`ifdef STOP_WATCH_DEBOUNCE_EN
    // Short glitch must be filtered out entirely.
    press(1'b0, 5);
    chk("deb_glitch_state", state, 0);
`endif

    // Start: the first edge after asserting samples the button.
    btn_ss = 1'b1;
    repeat (3 + DEB_LAT) step();
    chk("start_early_state", state, 0);
    chk("start_early_run",   run_en, 0);
    step();
    chk("start_state", state, 1);
    chk("start_run",   run_en, 1);
    repeat (PRESS - 4 - DEB_LAT) step();
    btn_ss = 1'b0;
    repeat (SETTLE + 5) step();
    chk("start_held_once", state, 1);

    // Lap capture and frozen display.
    nrms = 1234;
    step();
    chk("run_disp_live", disp_ms, 1234);
    press(1'b1, PRESS);
    chk("lap_val",   lap_val, 1234);
    chk("lap_cnt",   lap_cnt, 1);
    chk("lap_state", state,   3);
    chk("lap_run",   run_en,  1);
    nrms = 1300;
    repeat (3) step();
    chk("lap_disp_frozen", disp_ms, 1234);
    press(1'b1, PRESS);
    chk("lap_back_state", state, 1);
    chk("lap_back_disp",  disp_ms, 1300);
    nrms = 1301;
    step();
    chk("lap_back_track", disp_ms, 1301);

    // Pause, then clear from PAUSE.
    press(1'b0, PRESS);
    chk("pause_state", state,  2);
    chk("pause_run",   run_en, 0);
    btn_lr = 1'b1;
    repeat (3 + DEB_LAT) step();
    chk("clr_before", cnt_clr, 0);
    chk("clr_before_state", state, 2);
    step();
    chk("clr_pulse",   cnt_clr, 1);
    chk("clr_run",     run_en,  0);
    chk("clr_state",   state,   0);
    chk("clr_lap_val", lap_val, 0);
    chk("clr_lap_cnt", lap_cnt, 0);
    step();
    chk("clr_after", cnt_clr, 0);
    repeat (PRESS - 5 - DEB_LAT) step();
    btn_lr = 1'b0;
    repeat (SETTLE) step();
    chk("clr_idle_hold", state, 0);

    // Lap/reset is ignored in IDLE.
    press(1'b1, PRESS);
    chk("idle_lr_ignored", state, 0);

    // Simultaneous press from RUN with one lap already taken.
    press(1'b0, PRESS);
    nrms = 55;
    press(1'b1, PRESS);
    press(1'b1, PRESS);
    chk("sim_pre_cnt", lap_cnt, 1);
    chk("sim_pre_state", state, 1);
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    repeat (PRESS) step();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (SETTLE) step();
    chk("sim_state",   state,   2);
    chk("sim_lap_cnt", lap_cnt, 1);
    chk("sim_lap_val", lap_val, 55);

    // Saturation: 17 further laps from RUN.
    press(1'b0, PRESS);
    for (int i = 0; i < 17; i++) begin
      nrms = 1000 + i;
      press(1'b1, PRESS);
      press(1'b1, PRESS);
    end
    chk("sat_lap_cnt", lap_cnt, 15);
    chk("sat_lap_val", lap_val, 1016);
    chk("sat_state",   state,   1);

    // Enter LAP so every output is nonzero, then reset between edges.
    nrms = 2000;
    press(1'b1, PRESS);
    chk("prerst_state", state, 3);
    chk("prerst_disp",  disp_ms, 2000);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_state",   state,   0);
    chk("async_run",     run_en,  0);
    chk("async_cnt_clr", cnt_clr, 0);
    chk("async_lap_val", lap_val, 0);
    chk("async_lap_cnt", lap_cnt, 0);
    chk("async_disp",    disp_ms, 0);
    repeat (2) step();
    rst = 1'b1;
    step();

`ifdef STOP_WATCH_DEBOUNCE_EN
    // A 12-cycle press yields one event, DEB cycles later than undebounced.
    btn_ss = 1'b1;
    repeat (3 + DEB) step();
    chk("deb_press_early", state, 0);
    step();
    chk("deb_press_state", state, 1);
    btn_ss = 1'b0;
    repeat (SETTLE) step();
    chk("deb_press_once", state, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
